dbchecker_ctrl_initiator: RTL

AXI-Lite initiator that drives the DBChecker control slave port (`s_axil_ctrl_*`) from a simple request/response command interface. A management engine or a test sequencer uses it to program and read back checker registers. It serialises one register access at a time and issues the AW and W channels independently. It reports the AXI response code and, optionally, a response timeout.

---
 rtl/dbchecker_ctrl_pkg.sv | 35 +++
 rtl/dbchecker_ctrl_timeout.sv | 56 +++++
 rtl/dbchecker_ctrl_initiator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbchecker_ctrl_pkg.sv
// Shared types and constants for the DBChecker control-port AXI-Lite initiator.
package dbchecker_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RRESP = 3'd4,
        ST_RSP   = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ctrl_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } ctrl_rsp_t;

    // Registers are word-addressed on the bus; the byte offset is dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dbchecker_ctrl_timeout.sv
// Response-wait watchdog: counts cycles spent waiting for B/R and tracks an
// orphaned transaction whose late response must still be absorbed.
// Only instantiated when DBCHECKER_CTRL_TIMEOUT_EN is defined.
module dbchecker_ctrl_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic wait_i,
    input  logic hs_i,
    input  logic absorb_i,
    output logic expire_o,
    output logic orphan_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        orphan_q;
    logic        orphan_d;

    assign expire_o = wait_i && (cnt_q == LIMIT);
    assign orphan_o = orphan_q;

    // Counter runs only while waiting, so it is zero on every wait-state entry.
    always_comb begin
        cnt_d    = cnt_q;
        orphan_d = orphan_q;
        if (wait_i && !expire_o) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
        // A handshake in the expiry cycle wins, so no orphan is recorded then.
        if (expire_o && !hs_i) begin
            orphan_d = 1'b1;
        end else if (absorb_i) begin
            orphan_d = 1'b0;
        end else begin
            orphan_d = orphan_q;
        end
    end

    // Counter and orphan state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 16'd0;
            orphan_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: rtl/dbchecker_ctrl_initiator.sv
// AXI-Lite initiator for the DBChecker control slave. Serialises one register
// access at a time from a request/response command interface.
// Optional response timeout enabled by defining DBCHECKER_CTRL_TIMEOUT_EN.
module dbchecker_ctrl_initiator
    import dbchecker_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  CTRL_PROT      = 3'b000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] m_axil_ctrl_awaddr,
    output logic [2:0]  m_axil_ctrl_awprot,
    output logic        m_axil_ctrl_awvalid,
    input  logic        m_axil_ctrl_awready,
    output logic [31:0] m_axil_ctrl_wdata,
    output logic [3:0]  m_axil_ctrl_wstrb,
    output logic        m_axil_ctrl_wvalid,
    input  logic        m_axil_ctrl_wready,
    input  logic [1:0]  m_axil_ctrl_bresp,
    input  logic        m_axil_ctrl_bvalid,
    output logic        m_axil_ctrl_bready,
    output logic [31:0] m_axil_ctrl_araddr,
    output logic [2:0]  m_axil_ctrl_arprot,
    output logic        m_axil_ctrl_arvalid,
    input  logic        m_axil_ctrl_arready,
    input  logic [31:0] m_axil_ctrl_rdata,
    input  logic [1:0]  m_axil_ctrl_rresp,
    input  logic        m_axil_ctrl_rvalid,
    output logic        m_axil_ctrl_rready
);

    ctrl_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    ctrl_rsp_t   rsp_q, rsp_d;

    ctrl_req_t   req_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        b_hs_s;
    logic        r_hs_s;
    logic        absorb_s;
    logic        expire_s;
    logic        orphan_s;

    assign req_s    = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
    assign aw_hs_s  = awvalid_q && m_axil_ctrl_awready;
    assign w_hs_s   = wvalid_q && m_axil_ctrl_wready;
    assign b_hs_s   = bready_q && m_axil_ctrl_bvalid;
    assign r_hs_s   = rready_q && m_axil_ctrl_rvalid;
    // A B/R handshake outside the wait states can only be a late orphan response.
    assign absorb_s = ((state_q == ST_IDLE) || (state_q == ST_RSP)) && (b_hs_s || r_hs_s);

`ifdef DBCHECKER_CTRL_TIMEOUT_EN
    logic wait_s;
    logic hs_s;

    assign wait_s = (state_q == ST_WRESP) || (state_q == ST_RRESP);
    assign hs_s   = ((state_q == ST_WRESP) && b_hs_s) || ((state_q == ST_RRESP) && r_hs_s);

    dbchecker_ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset_n  (reset_n),
        .wait_i   (wait_s),
        .hs_i     (hs_s),
        .absorb_i (absorb_s),
        .expire_o (expire_s),
        .orphan_o (orphan_s)
    );
`else
    assign expire_s = 1'b0;
    assign orphan_s = 1'b0;
`endif

    // Next-state logic for the transaction FSM and every registered bus output.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = word_align(req_s.addr);
                    wdata_d = req_s.wdata;
                    wstrb_d = req_s.wstrb;
                    if (req_s.write) begin
                        state_d   = ST_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                if (absorb_s) begin
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                end else begin
                    bready_d = bready_q;
                    rready_d = rready_q;
                end
            end
            ST_WADDR: begin
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                end else begin
                    state_d = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: 32'h0000_0000, resp: m_axil_ctrl_bresp, timeout: 1'b0};
                end else if (expire_s) begin
                    // bready stays high so the late B is swallowed.
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: 32'h0000_0000, resp: RESP_SLVERR, timeout: 1'b1};
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (m_axil_ctrl_arready) begin
                    state_d   = ST_RRESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d = ST_RADDR;
                end
            end
            ST_RRESP: begin
                if (r_hs_s) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: m_axil_ctrl_rdata, resp: m_axil_ctrl_rresp, timeout: 1'b0};
                end else if (expire_s) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: 32'h0000_0000, resp: RESP_SLVERR, timeout: 1'b1};
                end else begin
                    state_d = ST_RRESP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RSP;
                end
                if (absorb_s) begin
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                end else begin
                    bready_d = bready_q;
                    rready_d = rready_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE) && (!orphan_s || absorb_s);
    end

    // State and output registers; reset aborts any transaction without a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '{rdata: 32'h0000_0000, resp: RESP_OKAY, timeout: 1'b0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_q.rdata;
    assign rsp_resp            = rsp_q.resp;
    assign rsp_timeout         = rsp_q.timeout;
    assign m_axil_ctrl_awaddr  = addr_q;
    assign m_axil_ctrl_awprot  = CTRL_PROT;
    assign m_axil_ctrl_awvalid = awvalid_q;
    assign m_axil_ctrl_wdata   = wdata_q;
    assign m_axil_ctrl_wstrb   = wstrb_q;
    assign m_axil_ctrl_wvalid  = wvalid_q;
    assign m_axil_ctrl_bready  = bready_q;
    assign m_axil_ctrl_araddr  = addr_q;
    assign m_axil_ctrl_arprot  = CTRL_PROT;
    assign m_axil_ctrl_arvalid = arvalid_q;
    assign m_axil_ctrl_rready  = rready_q;

endmodule
